// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops the CDB for producer results and issues the oldest ready op through a
// registered output stage.

// Simulation checker: the issue select is at most one-hot and dispatch only ever
// writes a single, currently free slot.
module alu_reservation_station_chk #(
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic [DEPTH-1:0] i_sel,
   input logic [DEPTH-1:0] i_alloc,
   input logic [DEPTH-1:0] i_valid,
   input logic             i_fire
);
   a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(i_sel));
   a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n)
      i_fire |-> ($onehot(i_alloc) && ((i_alloc & i_valid) == '0)));
endmodule

module alu_reservation_station #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int CTL_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_flush,
   input  logic                  i_disp_valid,
   output logic                  o_disp_ready,
   input  logic [CTL_WIDTH-1:0]  i_disp_alu_ctl,
   input  logic [TAG_WIDTH-1:0]  i_disp_tag,
   input  logic                  i_disp_op1_rdy,
   input  logic [DATA_WIDTH-1:0] i_disp_op1_val,
   input  logic [TAG_WIDTH-1:0]  i_disp_op1_tag,
   input  logic                  i_disp_op2_rdy,
   input  logic [DATA_WIDTH-1:0] i_disp_op2_val,
   input  logic [TAG_WIDTH-1:0]  i_disp_op2_tag,
   input  logic                  i_cdb_valid,
   input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
   input  logic [DATA_WIDTH-1:0] i_cdb_value,
   input  logic                  i_alu_ready,
   output logic                  o_out_valid,
   output logic [CTL_WIDTH-1:0]  o_out_alu_ctl,
   output logic [TAG_WIDTH-1:0]  o_out_tag,
   output logic [DATA_WIDTH-1:0] o_out_op1,
   output logic [DATA_WIDTH-1:0] o_out_op2
);
   // entry storage
   logic [DEPTH-1:0]      r_valid;
   logic [DEPTH-1:0]      r_op1_rdy;
   logic [DEPTH-1:0]      r_op2_rdy;
   logic [CTL_WIDTH-1:0]  r_ctl     [DEPTH];
   logic [TAG_WIDTH-1:0]  r_tag     [DEPTH];
   logic [TAG_WIDTH-1:0]  r_op1_tag [DEPTH];
   logic [TAG_WIDTH-1:0]  r_op2_tag [DEPTH];
   logic [DATA_WIDTH-1:0] r_op1_val [DEPTH];
   logic [DATA_WIDTH-1:0] r_op2_val [DEPTH];
   // r_older[i][j] = 1 when entry j was allocated before entry i
   logic [DEPTH-1:0]      r_older   [DEPTH];

   // issue stage
   logic                  r_out_valid;
   logic [CTL_WIDTH-1:0]  r_out_ctl;
   logic [TAG_WIDTH-1:0]  r_out_tag;
   logic [DATA_WIDTH-1:0] r_out_op1;
   logic [DATA_WIDTH-1:0] r_out_op2;

   logic [DEPTH-1:0]      w_free;
   logic [DEPTH-1:0]      w_alloc;
   logic [DEPTH-1:0]      w_ready;
   logic [DEPTH-1:0]      w_sel;
   logic                  w_fire;
   logic                  w_issue;
   logic                  w_d1_hit;
   logic                  w_d2_hit;
   logic [DATA_WIDTH-1:0] w_d1_val;
   logic [DATA_WIDTH-1:0] w_d2_val;
   logic [CTL_WIDTH-1:0]  w_sel_ctl;
   logic [TAG_WIDTH-1:0]  w_sel_tag;
   logic [DATA_WIDTH-1:0] w_sel_op1;
   logic [DATA_WIDTH-1:0] w_sel_op2;

   // lowest free slot (isolate lowest set bit of the free vector) and dispatch handshake
   always_comb begin
      w_free       = ~r_valid;
      w_alloc      = w_free & (~w_free + DEPTH'(1));
      o_disp_ready = |w_free;
      w_fire       = i_disp_valid & (|w_free) & ~i_flush;
   end

   // same-cycle CDB capture for operands arriving with dispatch
   always_comb begin
      w_d1_hit = i_cdb_valid & ~i_disp_op1_rdy & (i_disp_op1_tag == i_cdb_tag);
      w_d2_hit = i_cdb_valid & ~i_disp_op2_rdy & (i_disp_op2_tag == i_cdb_tag);
      w_d1_val = i_disp_op1_rdy ? i_disp_op1_val : i_cdb_value;
      w_d2_val = i_disp_op2_rdy ? i_disp_op2_val : i_cdb_value;
   end

   // oldest-ready select: a ready entry with no older ready entry
   always_comb begin
      w_ready = r_valid & r_op1_rdy & r_op2_rdy;
      w_sel   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_sel[i] = w_ready[i] & ~(|(r_older[i] & w_ready));
      end
      w_issue = (~r_out_valid | i_alu_ready) & (|w_ready);
   end

   // one-hot AND-OR mux of the selected entry's fields
   always_comb begin
      w_sel_ctl = '0;
      w_sel_tag = '0;
      w_sel_op1 = '0;
      w_sel_op2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_sel_ctl = w_sel_ctl | (r_ctl[i]     & {CTL_WIDTH{w_sel[i]}});
         w_sel_tag = w_sel_tag | (r_tag[i]     & {TAG_WIDTH{w_sel[i]}});
         w_sel_op1 = w_sel_op1 | (r_op1_val[i] & {DATA_WIDTH{w_sel[i]}});
         w_sel_op2 = w_sel_op2 | (r_op2_val[i] & {DATA_WIDTH{w_sel[i]}});
      end
   end

   // entry state: allocate, wake up from the CDB, free on issue, squash on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_op1_rdy <= '0;
         r_op2_rdy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ctl[i]     <= '0;
            r_tag[i]     <= '0;
            r_op1_tag[i] <= '0;
            r_op2_tag[i] <= '0;
            r_op1_val[i] <= '0;
            r_op2_val[i] <= '0;
            r_older[i]   <= '0;
         end
      end else if (i_flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_fire && w_alloc[i]) begin
               r_valid[i]   <= 1'b1;
               r_ctl[i]     <= i_disp_alu_ctl;
               r_tag[i]     <= i_disp_tag;
               r_op1_rdy[i] <= i_disp_op1_rdy | w_d1_hit;
               r_op1_val[i] <= w_d1_val;
               r_op1_tag[i] <= i_disp_op1_tag;
               r_op2_rdy[i] <= i_disp_op2_rdy | w_d2_hit;
               r_op2_val[i] <= w_d2_val;
               r_op2_tag[i] <= i_disp_op2_tag;
               // every currently occupied entry is older than the new one
               r_older[i]   <= r_valid;
            end else begin
               if (w_issue && w_sel[i]) begin
                  r_valid[i] <= 1'b0;
               end
               if (r_valid[i] && !r_op1_rdy[i] && i_cdb_valid && (r_op1_tag[i] == i_cdb_tag)) begin
                  r_op1_rdy[i] <= 1'b1;
                  r_op1_val[i] <= i_cdb_value;
               end
               if (r_valid[i] && !r_op2_rdy[i] && i_cdb_valid && (r_op2_tag[i] == i_cdb_tag)) begin
                  r_op2_rdy[i] <= 1'b1;
                  r_op2_val[i] <= i_cdb_value;
               end
               // the newly allocated slot is younger than everyone: clear its column
               if (w_fire) begin
                  r_older[i] <= r_older[i] & ~w_alloc;
               end
            end
         end
      end
   end

   // registered issue stage: load on issue, drain when the ALU takes it, hold on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_ctl   <= '0;
         r_out_tag   <= '0;
         r_out_op1   <= '0;
         r_out_op2   <= '0;
      end else if (i_flush) begin
         r_out_valid <= 1'b0;
      end else if (w_issue) begin
         r_out_valid <= 1'b1;
         r_out_ctl   <= w_sel_ctl;
         r_out_tag   <= w_sel_tag;
         r_out_op1   <= w_sel_op1;
         r_out_op2   <= w_sel_op2;
      end else if (i_alu_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_valid   = r_out_valid;
   assign o_out_alu_ctl = r_out_ctl;
   assign o_out_tag     = r_out_tag;
   assign o_out_op1     = r_out_op1;
   assign o_out_op2     = r_out_op2;

   alu_reservation_station_chk #(.DEPTH(DEPTH)) u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sel   (w_sel),
      .i_alloc (w_alloc),
      .i_valid (r_valid),
      .i_fire  (w_fire)
   );
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vector table, hand sequences for
// the multi-cycle corners, then random traffic against an in-order queue model.
module tb_alu_reservation_station;
   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int TW    = 4;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush, disp_valid, disp_ready, disp_op1_rdy, disp_op2_rdy;
   logic [CW-1:0] disp_alu_ctl, out_alu_ctl;
   logic [TW-1:0] disp_tag, disp_op1_tag, disp_op2_tag, cdb_tag, out_tag;
   logic [DW-1:0] disp_op1_val, disp_op2_val, cdb_value, out_op1, out_op2;
   logic          cdb_valid, alu_ready, out_valid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_reservation_station #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CTL_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .i_flush(flush),
      .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
      .i_disp_alu_ctl(disp_alu_ctl), .i_disp_tag(disp_tag),
      .i_disp_op1_rdy(disp_op1_rdy), .i_disp_op1_val(disp_op1_val), .i_disp_op1_tag(disp_op1_tag),
      .i_disp_op2_rdy(disp_op2_rdy), .i_disp_op2_val(disp_op2_val), .i_disp_op2_tag(disp_op2_tag),
      .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_value(cdb_value),
      .i_alu_ready(alu_ready), .o_out_valid(out_valid), .o_out_alu_ctl(out_alu_ctl),
      .o_out_tag(out_tag), .o_out_op1(out_op1), .o_out_op2(out_op2)
   );

   // ---------------- reference model: entries kept in dispatch (age) order ----------------
   typedef struct {
      logic [CW-1:0] ctl;
      logic [TW-1:0] tag;
      bit            r1;
      logic [DW-1:0] v1;
      logic [TW-1:0] t1;
      bit            r2;
      logic [DW-1:0] v2;
      logic [TW-1:0] t2;
   } ent_t;

   ent_t mq[$];
   bit   m_ov;
   ent_t m_out;

   task automatic model_step();
      int   n0;
      int   idx;
      ent_t e;
      if (flush) begin
         mq.delete();
         m_ov = 1'b0;
         return;
      end
      n0  = mq.size();
      idx = -1;
      if (!m_ov || alu_ready) begin
         foreach (mq[k]) if (idx < 0 && mq[k].r1 && mq[k].r2) idx = k;
         if (idx >= 0) begin
            m_out = mq[idx];
            m_ov  = 1'b1;
            mq.delete(idx);
         end else if (alu_ready) begin
            m_ov = 1'b0;
         end
      end
      if (cdb_valid) begin
         foreach (mq[k]) begin
            if (!mq[k].r1 && mq[k].t1 == cdb_tag) begin mq[k].r1 = 1'b1; mq[k].v1 = cdb_value; end
            if (!mq[k].r2 && mq[k].t2 == cdb_tag) begin mq[k].r2 = 1'b1; mq[k].v2 = cdb_value; end
         end
      end
      if (disp_valid && n0 < DEPTH) begin
         e.ctl = disp_alu_ctl; e.tag = disp_tag;
         e.r1 = disp_op1_rdy;  e.v1 = disp_op1_val; e.t1 = disp_op1_tag;
         e.r2 = disp_op2_rdy;  e.v2 = disp_op2_val; e.t2 = disp_op2_tag;
         if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_value; end
         if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_value; end
         mq.push_back(e);
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; disp_valid = 1'b0; disp_alu_ctl = '0; disp_tag = '0;
      disp_op1_rdy = 1'b0; disp_op1_val = '0; disp_op1_tag = '0;
      disp_op2_rdy = 1'b0; disp_op2_val = '0; disp_op2_tag = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; alu_ready = 1'b1;
   endtask

   task automatic disp(input int ctl, input int tag, input int r1, input int v1, input int t1,
                       input int r2, input int v2, input int t2);
      disp_valid = 1'b1; disp_alu_ctl = CW'(ctl); disp_tag = TW'(tag);
      disp_op1_rdy = r1[0]; disp_op1_val = DW'(v1); disp_op1_tag = TW'(t1);
      disp_op2_rdy = r2[0]; disp_op2_val = DW'(v2); disp_op2_tag = TW'(t2);
   endtask

   task automatic cdb(input int tag, input int val);
      cdb_valid = 1'b1; cdb_tag = TW'(tag); cdb_value = DW'(val);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int dv, ctl, tag, r1, v1, t1, r2, v2, t2, cv, ct, cval, ar, fl;
      int eov, etag, eop1, eop2, edr;
   } vec_t;

   vec_t tv[9];
   int   wt[3];

   initial begin
      tv = '{
         '{1,0,3, 1,5,0,  1,7,0, 0,0,0,  1,0, 0,0,0,0,1},   // ready ADD dispatched
         '{0,0,0, 0,0,0,  0,0,0, 0,0,0,  1,0, 1,3,5,7,1},   // issues one cycle later
         '{1,1,4, 0,0,2,  1,1,0, 0,0,0,  1,0, 0,0,0,0,1},   // op1 waits on tag 2
         '{0,0,0, 0,0,0,  0,0,0, 0,0,0,  1,0, 0,0,0,0,1},
         '{0,0,0, 0,0,0,  0,0,0, 1,2,16, 1,0, 0,0,0,0,1},   // broadcast tag 2
         '{0,0,0, 0,0,0,  0,0,0, 0,0,0,  1,0, 1,4,16,1,1},  // issues with 0x10
         '{1,2,5, 1,11,0, 0,0,6, 1,6,9,  1,0, 0,0,0,0,1},   // same-cycle capture
         '{0,0,0, 0,0,0,  0,0,0, 0,0,0,  1,0, 1,5,11,9,1},
         '{0,0,0, 0,0,0,  0,0,0, 0,0,0,  1,0, 0,0,0,0,1}
      };
      wt = '{12, 13, 15};

      idle();
      rst_n = 1'b0;
      mq.delete();
      m_ov = 1'b0;
      #12;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_tag", 32'(out_tag), 32'd0);
      chk("rst out_ctl", 32'(out_alu_ctl), 32'd0);
      chk("rst out_op1", out_op1, 32'd0);
      chk("rst out_op2", out_op2, 32'd0);
      #9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst disp_ready", 32'(disp_ready), 32'd1);

      foreach (tv[k]) begin
         idle();
         disp_valid = tv[k].dv[0]; disp_alu_ctl = CW'(tv[k].ctl); disp_tag = TW'(tv[k].tag);
         disp_op1_rdy = tv[k].r1[0]; disp_op1_val = DW'(tv[k].v1); disp_op1_tag = TW'(tv[k].t1);
         disp_op2_rdy = tv[k].r2[0]; disp_op2_val = DW'(tv[k].v2); disp_op2_tag = TW'(tv[k].t2);
         cdb_valid = tv[k].cv[0]; cdb_tag = TW'(tv[k].ct); cdb_value = DW'(tv[k].cval);
         alu_ready = tv[k].ar[0]; flush = tv[k].fl[0];
         tick();
         chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tv[k].eov));
         chk($sformatf("vec%0d disp_ready", k), 32'(disp_ready), 32'(tv[k].edr));
         if (tv[k].eov != 0) begin
            chk($sformatf("vec%0d out_tag", k), 32'(out_tag), 32'(tv[k].etag));
            chk($sformatf("vec%0d out_op1", k), out_op1, 32'(tv[k].eop1));
            chk($sformatf("vec%0d out_op2", k), out_op2, 32'(tv[k].eop2));
         end
      end

      // full station: 5th dispatch ignored, waking entry 2 frees a slot
      for (int k = 0; k < 4; k++) begin
         idle(); disp(1, 8 + k, 0, 0, 12 + k, 1, 3, 0); tick();
      end
      chk("full disp_ready", 32'(disp_ready), 32'd0);
      idle(); disp(1, 7, 1, 1, 0, 1, 2, 0); tick();
      chk("full ignored out_valid", 32'(out_valid), 32'd0);
      chk("full ignored disp_ready", 32'(disp_ready), 32'd0);
      idle(); tick();
      chk("full ignored stays quiet", 32'(out_valid), 32'd0);
      idle(); cdb(14, 'h22); tick();
      chk("wake no early issue", 32'(out_valid), 32'd0);
      chk("wake disp_ready", 32'(disp_ready), 32'd0);
      idle(); tick();
      chk("wake issue valid", 32'(out_valid), 32'd1);
      chk("wake issue tag", 32'(out_tag), 32'd10);
      chk("wake issue op1", out_op1, 32'h22);
      chk("wake issue op2", out_op2, 32'd3);
      chk("wake disp_ready after", 32'(disp_ready), 32'd1);

      // flush with 3 entries, out_valid held, and a concurrent ready dispatch
      idle(); alu_ready = 1'b0; tick();
      chk("flush pre out_valid", 32'(out_valid), 32'd1);
      idle(); alu_ready = 1'b0; flush = 1'b1; disp(3, 6, 1, 4, 0, 1, 4, 0); tick();
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush disp_ready", 32'(disp_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         idle(); cdb(wt[k], 'h55); tick();
         chk($sformatf("flush quiet %0d", k), 32'(out_valid), 32'd0);
      end
      idle(); tick();
      chk("flush quiet end", 32'(out_valid), 32'd0);

      // age order: B allocated to slot 1 before A lands in slot 0; both wake together
      idle(); disp(4, 12, 1, 'h5, 0, 1, 'h6, 0); tick();
      idle(); disp(5, 1, 0, 0, 9, 1, 'hB, 0); tick();
      chk("age X valid", 32'(out_valid), 32'd1);
      chk("age X tag", 32'(out_tag), 32'd12);
      idle(); disp(6, 2, 0, 0, 9, 1, 'hA, 0); tick();
      chk("age idle", 32'(out_valid), 32'd0);
      idle(); cdb(9, 'h99); tick();
      chk("age wake no issue", 32'(out_valid), 32'd0);
      idle(); alu_ready = 1'b0; tick();
      chk("age B valid", 32'(out_valid), 32'd1);
      chk("age B tag", 32'(out_tag), 32'd1);
      chk("age B op1", out_op1, 32'h99);
      chk("age B op2", out_op2, 32'hB);
      for (int k = 0; k < 3; k++) begin
         idle(); alu_ready = 1'b0; tick();
         chk($sformatf("stall%0d valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("stall%0d tag", k), 32'(out_tag), 32'd1);
         chk($sformatf("stall%0d op2", k), out_op2, 32'hB);
         chk($sformatf("stall%0d ctl", k), 32'(out_alu_ctl), 32'd5);
      end
      idle(); tick();
      chk("age A valid", 32'(out_valid), 32'd1);
      chk("age A tag", 32'(out_tag), 32'd2);
      chk("age A op1", out_op1, 32'h99);
      chk("age A op2", out_op2, 32'hA);
      idle(); tick();
      chk("age drained", 32'(out_valid), 32'd0);

      // random traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         disp_valid   = 1'($urandom_range(0, 1));
         disp_alu_ctl = CW'($urandom_range(0, 31));
         disp_tag     = TW'($urandom_range(0, 15));
         disp_op1_rdy = 1'($urandom_range(0, 1));
         disp_op1_val = $urandom;
         disp_op1_tag = TW'($urandom_range(0, 7));
         disp_op2_rdy = 1'($urandom_range(0, 1));
         disp_op2_val = $urandom;
         disp_op2_tag = TW'($urandom_range(0, 7));
         cdb_valid    = 1'($urandom_range(0, 1));
         cdb_tag      = TW'($urandom_range(0, 7));
         cdb_value    = $urandom;
         alu_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 49) == 0);
         tick();
         chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(m_ov));
         chk($sformatf("rnd%0d disp_ready", c), 32'(disp_ready), 32'(mq.size() < DEPTH));
         if (m_ov) begin
            chk($sformatf("rnd%0d out_ctl", c), 32'(out_alu_ctl), 32'(m_out.ctl));
            chk($sformatf("rnd%0d out_tag", c), 32'(out_tag), 32'(m_out.tag));
            chk($sformatf("rnd%0d out_op1", c), out_op1, m_out.v1);
            chk($sformatf("rnd%0d out_op2", c), out_op2, m_out.v2);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
